// File: rtl/key_gate_encoder_if.sv
// Scan-code input and gate/note output bundle for key_gate_encoder.
// The byte source (PS/2 receiver) drives through the master modport and
// the encoder consumes through the slave modport.
interface key_gate_encoder_if;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic        keyboard_pushed;
    logic [3:0]  note_index;
    logic        note_valid;
    logic [12:0] held_mask;

    modport master (
        output scan_code,
        output scan_valid,
        input  keyboard_pushed,
        input  note_index,
        input  note_valid,
        input  held_mask
    );

    modport slave (
        input  scan_code,
        input  scan_valid,
        output keyboard_pushed,
        output note_index,
        output note_valid,
        output held_mask
    );
endinterface

// File: rtl/key_gate_encoder.sv
// key_gate_encoder: turns the PS/2 scan-code byte stream into a one-octave
// held-key map, a last-pressed-wins note selection and an envelope gate.
// Whenever the sounding note changes while the gate is high, the gate is
// pulled low for GAP_CYCLES cycles so the envelope retriggers its attack.
module key_gate_encoder #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic               clock,
    input  logic               resetn,
    key_gate_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        P_IDLE,
        P_BRK,
        P_EXT,
        P_EXTBRK
    } parseState_t;

    typedef enum logic [1:0] {
        G_OFF,
        G_ON,
        G_GAP
    } gateState_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    parseState_t r_parse;
    gateState_t  r_gate;
    logic [7:0]  r_gapCnt;
    logic [12:0] r_heldMask;
    logic [3:0]  r_noteIndex;
    logic        r_noteValid;
    logic        r_pushed;

    logic        w_mapped;
    logic [3:0]  w_key;
    logic [12:0] w_keyBit;
    logic        w_isHeld;
    logic        w_newPress;
    logic        w_release;
    logic        w_relCurrent;
    logic [12:0] w_remaining;
    logic        w_othersHeld;
    logic [3:0]  w_highest;

    // Translate the incoming byte into a key index of the one-octave map.
    always_comb begin
        w_mapped = 1'b1;
        w_key    = 4'd0;
        case (bus.scan_code)
            8'h1C:   w_key = 4'd0;
            8'h1D:   w_key = 4'd1;
            8'h1B:   w_key = 4'd2;
            8'h24:   w_key = 4'd3;
            8'h23:   w_key = 4'd4;
            8'h2B:   w_key = 4'd5;
            8'h2C:   w_key = 4'd6;
            8'h34:   w_key = 4'd7;
            8'h35:   w_key = 4'd8;
            8'h33:   w_key = 4'd9;
            8'h3C:   w_key = 4'd10;
            8'h3B:   w_key = 4'd11;
            8'h42:   w_key = 4'd12;
            default: w_mapped = 1'b0;
        endcase
    end

    assign w_keyBit     = 13'(1) << w_key;
    assign w_isHeld     = |(r_heldMask & w_keyBit);
    assign w_remaining  = r_heldMask & ~w_keyBit;
    assign w_othersHeld = |w_remaining;
    assign w_newPress   = bus.scan_valid && (r_parse == P_IDLE) && w_mapped && !w_isHeld;
    assign w_release    = bus.scan_valid && (r_parse == P_BRK) && w_mapped && w_isHeld;
    assign w_relCurrent = w_release && (w_key == r_noteIndex);

    // Pick the highest key still held after a release; it becomes the fallback note.
    always_comb begin
        w_highest = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (w_remaining[i]) begin
                w_highest = 4'(i);
            end
        end
    end

    // Parser, key map, note selection and gate FSM, all with registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_parse     <= P_IDLE;
            r_gate      <= G_OFF;
            r_gapCnt    <= 8'd0;
            r_heldMask  <= 13'd0;
            r_noteIndex <= 4'd0;
            r_noteValid <= 1'b0;
            r_pushed    <= 1'b0;
        end else begin
            if (bus.scan_valid) begin
                case (r_parse)
                    P_IDLE: begin
                        if (bus.scan_code == 8'hE0) begin
                            r_parse <= P_EXT;
                        end else if (bus.scan_code == 8'hF0) begin
                            r_parse <= P_BRK;
                        end
                    end
                    P_EXT: begin
                        if (bus.scan_code == 8'hF0) begin
                            r_parse <= P_EXTBRK;
                        end else begin
                            r_parse <= P_IDLE;
                        end
                    end
                    default: r_parse <= P_IDLE;
                endcase
            end

            r_noteValid <= 1'b0;
            if (w_newPress) begin
                r_heldMask  <= r_heldMask | w_keyBit;
                r_noteIndex <= w_key;
                r_noteValid <= 1'b1;
            end else if (w_release) begin
                r_heldMask <= w_remaining;
                if (w_relCurrent && w_othersHeld) begin
                    r_noteIndex <= w_highest;
                    r_noteValid <= 1'b1;
                end
            end

            if (w_newPress && (r_gate == G_OFF)) begin
                r_gate   <= G_ON;
                r_pushed <= 1'b1;
            end else if (w_newPress || (w_relCurrent && w_othersHeld)) begin
                r_gate   <= G_GAP;
                r_gapCnt <= GAP_LOAD;
                r_pushed <= 1'b0;
            end else if (w_relCurrent) begin
                r_gate   <= G_OFF;
                r_gapCnt <= 8'd0;
                r_pushed <= 1'b0;
            end else if (r_gate == G_GAP) begin
                if (r_gapCnt <= 8'd1) begin
                    r_gate   <= G_ON;
                    r_gapCnt <= 8'd0;
                    r_pushed <= 1'b1;
                end else begin
                    r_gapCnt <= r_gapCnt - 8'd1;
                end
            end
        end
    end

    assign bus.keyboard_pushed = r_pushed;
    assign bus.note_index      = r_noteIndex;
    assign bus.note_valid      = r_noteValid;
    assign bus.held_mask       = r_heldMask;

endmodule

// File: tb/tb_key_gate_encoder.sv
// Testbench for key_gate_encoder: a table of hand-derived vectors, a reset
// in the middle of a gap, then random byte streams against a reference model.
module tb_key_gate_encoder;

    localparam int GAP = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    key_gate_encoder_if bus ();

    key_gate_encoder #(.GAP_CYCLES(GAP)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        valid;
        logic [7:0]  code;
        logic        expPushed;
        logic [3:0]  expNote;
        logic        expNv;
        logic [12:0] expHeld;
    } vec_t;

    vec_t vecs[$];

    // Reference model: set of held keys, the sounding note, whether a note
    // sounds at all, and how many gap cycles remain before the gate reopens.
    bit [12:0] mHeld;
    int        mNote;
    bit        mSounding;
    int        mGapLeft;
    bit        mNv;
    bit        mExt;
    bit        mBrk;

    function automatic int keyOf(input logic [7:0] c);
        case (c)
            8'h1C: return 0;
            8'h1D: return 1;
            8'h1B: return 2;
            8'h24: return 3;
            8'h23: return 4;
            8'h2B: return 5;
            8'h2C: return 6;
            8'h34: return 7;
            8'h35: return 8;
            8'h33: return 9;
            8'h3C: return 10;
            8'h3B: return 11;
            8'h42: return 12;
            default: return -1;
        endcase
    endfunction

    function automatic void modelReset();
        mHeld     = '0;
        mNote     = 0;
        mSounding = 0;
        mGapLeft  = 0;
        mNv       = 0;
        mExt      = 0;
        mBrk      = 0;
    endfunction

    function automatic void modelStep(input logic valid, input logic [7:0] code);
        bit gateTouched;
        bit found;
        int k;
        gateTouched = 0;
        mNv = 0;
        if (valid) begin
            k = keyOf(code);
            if (mBrk) begin
                if (!mExt && k >= 0 && mHeld[k]) begin
                    mHeld[k] = 1'b0;
                    if (k == mNote) begin
                        gateTouched = 1;
                        if (mHeld != 0) begin
                            found = 0;
                            for (int i = 12; i >= 0; i--) begin
                                if (!found && mHeld[i]) begin
                                    mNote = i;
                                    found = 1;
                                end
                            end
                            mNv      = 1;
                            mGapLeft = GAP;
                        end else begin
                            mSounding = 0;
                            mGapLeft  = 0;
                        end
                    end
                end
                mBrk = 0;
                mExt = 0;
            end else if (mExt) begin
                if (code == 8'hF0) mBrk = 1;
                else mExt = 0;
            end else if (code == 8'hE0) begin
                mExt = 1;
            end else if (code == 8'hF0) begin
                mBrk = 1;
            end else if (k >= 0 && !mHeld[k]) begin
                mHeld[k]    = 1'b1;
                mNote       = k;
                mNv         = 1;
                gateTouched = 1;
                if (mSounding) mGapLeft = GAP;
                else mSounding = 1;
            end
        end
        if (!gateTouched && mGapLeft > 0) mGapLeft--;
    endfunction

    function automatic void addVec(input logic v, input logic [7:0] c, input logic p,
                                   input logic [3:0] n, input logic nv, input logic [12:0] h);
        vec_t e;
        e.valid = v; e.code = c; e.expPushed = p; e.expNote = n; e.expNv = nv; e.expHeld = h;
        vecs.push_back(e);
    endfunction

    // Drive one cycle's input, let the edge happen, advance the model, then settle.
    task automatic applyStimulus(input logic valid, input logic [7:0] code);
        bus.scan_valid = valid;
        bus.scan_code  = code;
        @(posedge clock);
        modelStep(valid, code);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ep, input logic [3:0] en,
                               input logic env, input logic [12:0] eh);
        checks++;
        if (bus.keyboard_pushed !== ep) begin
            failures++;
            $display("[TB] FAIL %s keyboard_pushed got %0b want %0b", name, bus.keyboard_pushed, ep);
        end
        checks++;
        if (bus.note_index !== en) begin
            failures++;
            $display("[TB] FAIL %s note_index got %0d want %0d", name, bus.note_index, en);
        end
        checks++;
        if (bus.note_valid !== env) begin
            failures++;
            $display("[TB] FAIL %s note_valid got %0b want %0b", name, bus.note_valid, env);
        end
        checks++;
        if (bus.held_mask !== eh) begin
            failures++;
            $display("[TB] FAIL %s held_mask got %03h want %03h", name, bus.held_mask, eh);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mSounding && (mGapLeft == 0), 4'(mNote), mNv, 13'(mHeld));
    endtask

    task automatic doReset();
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        modelReset();
    endtask

    logic [7:0] pool[19] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
                             8'h33, 8'h3C, 8'h3B, 8'h42, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h15, 8'h00};

    initial begin
        // Press, gap on new key, repeats, non-current release, extended keys.
        addVec(1, 8'h1C, 1, 0, 1, 13'h001);
        addVec(0, 8'h00, 1, 0, 0, 13'h001);
        addVec(1, 8'h23, 0, 4, 1, 13'h011);
        addVec(0, 8'h00, 0, 4, 0, 13'h011);
        addVec(0, 8'h00, 0, 4, 0, 13'h011);
        addVec(0, 8'h00, 0, 4, 0, 13'h011);
        addVec(0, 8'h00, 1, 4, 0, 13'h011);
        addVec(1, 8'h1C, 1, 4, 0, 13'h011);
        addVec(1, 8'hF0, 1, 4, 0, 13'h011);
        addVec(1, 8'h1C, 1, 4, 0, 13'h010);
        addVec(1, 8'h1C, 0, 0, 1, 13'h011);
        addVec(1, 8'hF0, 0, 0, 0, 13'h011);
        addVec(1, 8'h23, 0, 0, 0, 13'h001);
        addVec(0, 8'h00, 0, 0, 0, 13'h001);
        addVec(0, 8'h00, 1, 0, 0, 13'h001);
        addVec(1, 8'hE0, 1, 0, 0, 13'h001);
        addVec(1, 8'h1C, 1, 0, 0, 13'h001);
        addVec(1, 8'hE0, 1, 0, 0, 13'h001);
        addVec(1, 8'hF0, 1, 0, 0, 13'h001);
        addVec(1, 8'h1C, 1, 0, 0, 13'h001);
        addVec(1, 8'h15, 1, 0, 0, 13'h001);
        addVec(1, 8'hF0, 1, 0, 0, 13'h001);
        addVec(1, 8'h42, 1, 0, 0, 13'h001);
        addVec(1, 8'hF0, 1, 0, 0, 13'h001);
        addVec(1, 8'h1C, 0, 0, 0, 13'h000);
        addVec(0, 8'h00, 0, 0, 0, 13'h000);
        // Release of the current note falls back to the remaining key.
        addVec(1, 8'h1C, 1, 0, 1, 13'h001);
        addVec(1, 8'h23, 0, 4, 1, 13'h011);
        addVec(1, 8'hF0, 0, 4, 0, 13'h011);
        addVec(1, 8'h23, 0, 0, 1, 13'h001);
        addVec(0, 8'h00, 0, 0, 0, 13'h001);
        addVec(0, 8'h00, 0, 0, 0, 13'h001);
        addVec(0, 8'h00, 0, 0, 0, 13'h001);
        addVec(0, 8'h00, 1, 0, 0, 13'h001);
        addVec(1, 8'hF0, 1, 0, 0, 13'h001);
        addVec(1, 8'h1C, 0, 0, 0, 13'h000);
        // Everything released during the gap: gate never reopens.
        addVec(1, 8'h1C, 1, 0, 1, 13'h001);
        addVec(1, 8'h23, 0, 4, 1, 13'h011);
        addVec(1, 8'hF0, 0, 4, 0, 13'h011);
        addVec(1, 8'h23, 0, 0, 1, 13'h001);
        addVec(1, 8'hF0, 0, 0, 0, 13'h001);
        addVec(1, 8'h1C, 0, 0, 0, 13'h000);
        for (int i = 0; i < 6; i++) addVec(0, 8'h00, 0, 0, 0, 13'h000);
        // Highest remaining key wins after the current one is released.
        addVec(1, 8'h1C, 1, 0, 1, 13'h001);
        addVec(1, 8'h42, 0, 12, 1, 13'h1001);
        addVec(1, 8'h24, 0, 3, 1, 13'h1009);
        addVec(1, 8'hF0, 0, 3, 0, 13'h1009);
        addVec(1, 8'h24, 0, 12, 1, 13'h1001);

        $display("[TB] reset and table vectors");
        doReset();
        #1;
        checkOutput("reset", 0, 0, 0, 13'h000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].code);
            checkOutput($sformatf("vec%0d", i), vecs[i].expPushed, vecs[i].expNote,
                        vecs[i].expNv, vecs[i].expHeld);
        end

        $display("[TB] reset asserted mid-gap with a pending F0");
        doReset();
        applyStimulus(1, 8'h1C);
        applyStimulus(1, 8'h23);
        applyStimulus(1, 8'hF0);
        checkOutput("preReset", 0, 4, 0, 13'h011);
        bus.scan_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("asyncReset", 0, 0, 0, 13'h000);
        @(negedge clock);
        resetn = 1'b1;
        modelReset();
        applyStimulus(1, 8'h1C);
        checkOutput("postResetPress", 1, 0, 1, 13'h001);
        applyStimulus(0, 8'h00);
        checkOutput("postResetIdle", 1, 0, 0, 13'h001);

        $display("[TB] random byte streams against the model");
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic       v;
            logic [7:0] c;
            v = ($urandom_range(0, 3) != 0);
            c = pool[$urandom_range(0, 18)];
            applyStimulus(v, c);
            checkModel($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_gate_encoder.md
Name: key_gate_encoder

Overview:
- Converts the PS/2 keyboard scan-code byte stream into the gate (keyboard_pushed) and note selection that drive the ADSR envelope and the tone generator.
- Tracks a 13-key one-octave map, gives priority to the last key pressed, and decodes make (press), break (release, F0 prefix) and extended (E0 prefix) sequences.
- Forces a short gate-low gap whenever the sounding note changes while the gate is high. The envelope restarts its attack only after the gate drops and rises again.

Parameters:
- GAP_CYCLES, 4, number of clock cycles the gate is held low on a note-change retrigger (legal range 1..255).

Ports:
- clock  input  1  system clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- scan_code  input  8  received scan-code byte, valid only when scan_valid=1
- scan_valid  input  1  one-cycle strobe, at most one byte per cycle
- keyboard_pushed  output  1  gate to the ADSR; 1 = note held
- note_index  output  4  currently selected note, 0..12
- note_valid  output  1  one-cycle pulse when note_index takes a new value
- held_mask  output  13  bit i = key i currently held

Behaviour:
- Reset (resetn=0, asynchronous): keyboard_pushed=0, note_index=0, note_valid=0, held_mask=0, parser in P_IDLE, gate FSM in G_OFF, gap counter=0.
- Key map, scan code to index:
  - 1C→0, 1D→1, 1B→2, 24→3, 23→4, 2B→5, 2C→6, 34→7, 35→8, 33→9, 3C→10, 3B→11, 42→12.
  - Any other code is "unmapped".
- Parser FSM, advancing only on scan_valid:
  - P_IDLE: E0→P_EXT; F0→P_BRK; mapped code→press event, stay P_IDLE; unmapped→P_IDLE.
  - P_BRK: mapped→release event; any byte→P_IDLE.
  - P_EXT: F0→P_EXTBRK; other→P_IDLE; the byte is ignored.
  - P_EXTBRK: any byte→P_IDLE; the byte is ignored.
  - Extended keys never produce events.
- Press of key k:
  - Sets held_mask[k].
  - If k is already held (typematic repeat): no other effect.
  - Otherwise note_index←k and note_valid pulses.
  - If the gate was G_OFF: go to G_ON.
  - If the gate was G_ON or G_GAP: go to G_GAP with the counter loaded to GAP_CYCLES. A press during G_GAP restarts the gap.
- Release of key k:
  - Clears held_mask[k]. Release of a key not held is ignored.
  - If k≠note_index: no further effect.
  - If k=note_index and other keys remain held: note_index←highest held index, note_valid pulses, gate→G_GAP (counter reloaded).
  - If k=note_index and no keys remain: gate→G_OFF immediately, including from G_GAP; note_index is unchanged.
- Gate FSM and output:
  - keyboard_pushed=1 only in G_ON.
  - G_GAP decrements the counter each cycle and enters G_ON in the cycle after the counter reaches 1, so the gate is low for exactly GAP_CYCLES cycles.
- Latency: a byte accepted at edge N updates held_mask, note_index, note_valid and keyboard_pushed at edge N+1. All outputs are registered.
- note_valid is low in every cycle without a note change. It never pulses for a repeat or a non-current release.
- Reset asserted mid-sequence (for example in P_BRK or G_GAP) discards all state. After deassertion the first byte is parsed from P_IDLE.

Test Plan:
- Press 1C, then after 20 idle cycles F0,1C → keyboard_pushed rises 1 cycle after 1C with note_index=0 and note_valid pulsed once; gate falls 1 cycle after the second 1C; held_mask returns to 0.
- Hold 1C, press 23 (GAP_CYCLES=4) → note_index=4, note_valid pulses, keyboard_pushed low exactly 4 cycles then high; held_mask=0x011.
- With 1C and 23 held (current 4), send F0,23 → note_index=0, 4-cycle gap then gate high. Then F0,1C → gate low, held_mask=0.
- Send 1C five times (typematic) → single note_valid pulse, gate never drops. Send E0,1C and E0,F0,1C → no change to any output.
- Hold 1C, press 23, then send F0,23 and F0,1C during the gap → gate goes to 0 and stays 0, no G_ON entry.
- Send F0 then assert resetn=0 mid-gap → all outputs 0 asynchronously. After release, the byte 1C is treated as a press (note 0, gate high), not a release.
